ff_bank: RTL and testbench

Parametrised multi-mode register bank: a WIDTH-bit register whose per-cycle update rule is selectable at run time as D, T, SR or JK, replacing single-bit, single-function flip-flop instances. The block adds a registered mode latch, a clock enable, SR/JK input-conflict reporting, a one-cycle change pulse and a saturating change counter. It is used wherever control/status bits need a configurable update rule, with software able to observe activity.

---
 rtl/ff_bank.sv | 89 ++++++++
 tb/tb_ff_bank.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ff_bank.sv
// ff_bank: WIDTH-bit register whose per-cycle update rule (D, T, SR, JK) is
// selected at run time through a registered mode. The block also reports
// SR/JK input conflicts, pulses when q changes, and keeps a saturating count
// of edges on which q changed.
module ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_ld,
    input  logic [1:0]       mode_in,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [1:0]       mode,
    output logic             changed,
    output logic             conflict,
    output logic [CNT_W-1:0] chg_cnt
);

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_SR = 2'b10,
        MODE_JK = 2'b11
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mode_t            mode_r;
    logic [WIDTH-1:0] q_next;
    logic             changed_next;
    logic             conflict_next;

    assign mode = mode_r;

    // Next value of q under the currently active mode, plus the change and
    // conflict conditions that accompany that update.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        q_next        = q;
        changed_next  = 1'b0;
        conflict_next = 1'b0;
        if (en) begin
            case (mode_r)
                MODE_D:  q_next = a;
                MODE_T:  q_next = q ^ a;
                MODE_SR: q_next = a | (~b & q);
                MODE_JK: q_next = (a & ~q) | (~b & q);
            endcase
            changed_next  = (q_next != q);
            conflict_next = ((mode_r == MODE_SR) || (mode_r == MODE_JK)) && ((a & b) != '0);
        end
    end

    // Register bank, mode latch and the one-cycle report pulses.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            q        <= RESET_VAL;
            mode_r   <= MODE_D;
            changed  <= 1'b0;
            conflict <= 1'b0;
        end else begin
            q        <= q_next;
            changed  <= changed_next;
            conflict <= conflict_next;
            if (mode_ld) begin
                mode_r <= mode_t'(mode_in);
            end
        end
    end

    // Saturating change counter; clear wins over an increment on the same edge.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            chg_cnt <= '0;
        end else if (changed_next && (chg_cnt != CNT_MAX)) begin
            chg_cnt <= chg_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank: directed and randomized stimulus for ff_bank, checked every
// cycle against a bit-level behavioural model, plus literal expectations.
module tb_ff_bank;

    localparam int          WIDTH     = 8;
    localparam logic [7:0]  RESET_VAL = 8'hA5;
    localparam int          CNT_W     = 2;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode_ld;
    logic [1:0]       mode_in;
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cnt_clr;
    logic [WIDTH-1:0] q;
    logic [1:0]       mode;
    logic             changed;
    logic             conflict;
    logic [CNT_W-1:0] chg_cnt;

    ff_bank #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode_ld (mode_ld),
        .mode_in (mode_in),
        .en      (en),
        .a       (a),
        .b       (b),
        .cnt_clr (cnt_clr),
        .q       (q),
        .mode    (mode),
        .changed (changed),
        .conflict(conflict),
        .chg_cnt (chg_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state, valid once the first reset has been applied.
    bit         mdl_valid = 1'b0;
    logic [7:0] m_q;
    int         m_mode;
    bit         m_changed;
    bit         m_conflict;
    int         m_cnt;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the spec's rules, and
    // return 1 time unit after the rising edge.
    task automatic step(input bit r, input bit ld, input int mi, input bit e,
                        input logic [7:0] av, input logic [7:0] bv, input bit clr);
        logic [7:0] nq;
        bit         ch;
        bit         cf;
        int         ncnt;
        int         nmode;
        rst = r; mode_ld = ld; mode_in = 2'(mi); en = e; a = av; b = bv; cnt_clr = clr;
        if (r) begin
            nq = RESET_VAL; nmode = 0; ch = 0; cf = 0; ncnt = 0;
        end else begin
            nq = m_q;
            if (e) begin
                for (int i = 0; i < WIDTH; i++) begin
                    case (m_mode)
                        0: nq[i] = av[i];
                        1: nq[i] = av[i] ? ~m_q[i] : m_q[i];
                        2: nq[i] = av[i] ? 1'b1 : (bv[i] ? 1'b0 : m_q[i]);
                        default: begin
                            if (av[i] && bv[i]) nq[i] = ~m_q[i];
                            else if (av[i])     nq[i] = 1'b1;
                            else if (bv[i])     nq[i] = 1'b0;
                            else                nq[i] = m_q[i];
                        end
                    endcase
                end
            end
            ch    = e && (nq != m_q);
            cf    = e && (m_mode >= 2) && ((av & bv) != 0);
            ncnt  = clr ? 0 : ((ch && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt);
            nmode = ld ? mi : m_mode;
        end
        @(posedge clk);
        #1;
        m_q = nq; m_mode = nmode; m_changed = ch; m_conflict = cf; m_cnt = ncnt;
        if (r) mdl_valid = 1'b1;
    endtask

    // Compare process: every cycle once the model is valid.
    always @(negedge clk) begin
        if (mdl_valid) begin
            check("q",        32'(q),        32'(m_q));
            check("mode",     32'(mode),     32'(m_mode));
            check("changed",  32'(changed),  32'(m_changed));
            check("conflict", 32'(conflict), 32'(m_conflict));
            check("chg_cnt",  32'(chg_cnt),  32'(m_cnt));
        end
    end

    initial begin
        rst = 1'b1; mode_ld = 1'b0; mode_in = 2'b00; en = 1'b0;
        a = '0; b = '0; cnt_clr = 1'b0;

        // Reset overrides mode_ld and en.
        step(1, 1, 3, 1, 8'hFF, 8'h00, 0);
        check("rst_q",        32'(q),        32'hA5);
        check("rst_mode",     32'(mode),     32'h0);
        check("rst_changed",  32'(changed),  32'h0);
        check("rst_conflict", 32'(conflict), 32'h0);
        check("rst_cnt",      32'(chg_cnt),  32'h0);

        // D, then mode load to T (loading edge still D).
        step(0, 0, 0, 1, 8'h3C, 8'h00, 0);
        check("d_q",       32'(q),       32'h3C);
        check("d_changed", 32'(changed), 32'h1);
        step(0, 1, 1, 1, 8'h0F, 8'h00, 0);
        check("ld_t_q",    32'(q),       32'h0F);
        check("ld_t_mode", 32'(mode),    32'h1);
        step(0, 0, 0, 1, 8'h0F, 8'h00, 0);
        check("t1_q",      32'(q),       32'h00);
        step(0, 0, 0, 1, 8'h0F, 8'h00, 0);
        check("t2_q",      32'(q),       32'h0F);
        check("sat_cnt",   32'(chg_cnt), 32'h3);

        // Back to 00 under T while loading SR.
        step(0, 1, 2, 1, 8'h0F, 8'h00, 0);
        check("ld_sr_q",   32'(q),       32'h00);
        step(0, 0, 0, 1, 8'hF0, 8'h30, 0);
        check("sr1_q",        32'(q),        32'hF0);
        check("sr1_conflict", 32'(conflict), 32'h1);
        step(0, 0, 0, 1, 8'h00, 8'h10, 0);
        check("sr2_q",        32'(q),        32'hE0);
        check("sr2_conflict", 32'(conflict), 32'h0);

        // JK: load with en=0, then toggle all, then hold.
        step(0, 1, 3, 0, 8'hFF, 8'hFF, 0);
        check("ld_jk_q", 32'(q), 32'hE0);
        step(0, 0, 0, 1, 8'hFF, 8'hFF, 0);
        check("jk1_q",        32'(q),        32'h1F);
        check("jk1_conflict", 32'(conflict), 32'h1);
        step(0, 0, 0, 1, 8'h00, 8'h00, 0);
        check("jk2_q",       32'(q),       32'h1F);
        check("jk2_changed", 32'(changed), 32'h0);

        // Hold with en=0 in every mode.
        for (int m = 0; m < 4; m++) begin
            step(0, 1, m, 0, 8'hFF, 8'hFF, 0);
            step(0, 0, 0, 0, 8'hFF, 8'hFF, 0);
            check("hold_q",        32'(q),        32'h1F);
            check("hold_changed",  32'(changed),  32'h0);
            check("hold_conflict", 32'(conflict), 32'h0);
            check("hold_cnt",      32'(chg_cnt),  32'h3);
        end

        // Counter: clear, then five toggling edges in T mode.
        step(0, 1, 1, 0, 8'h00, 8'h00, 1);
        check("clr_cnt", 32'(chg_cnt), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 1, 8'h01, 8'h00, 0);
            check("cnt_seq", 32'(chg_cnt), 32'((k < 3) ? k + 1 : 3));
        end
        step(0, 0, 0, 1, 8'h01, 8'h00, 1);
        check("clr_prio_changed", 32'(changed), 32'h1);
        check("clr_prio_cnt",     32'(chg_cnt), 32'h0);

        // Randomized traffic, checked each cycle by the compare process.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(31) == 0),
                 ($urandom_range(3) == 0),
                 int'($urandom_range(3)),
                 ($urandom_range(3) != 0),
                 8'($urandom),
                 8'($urandom),
                 ($urandom_range(15) == 0));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
